serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor built around a single full-subtractor cell and a borrow flip-flop.
- Computes diff = a - b - bin over WIDTH clock cycles, with a start/busy/done handshake.
- Serves as the sequential counterpart of the combinational full-adder datapath in the basic-arithmetic library.
- Intended for area-constrained datapaths that accept multi-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only when busy=0
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- bin  input  1  borrow-in; captured on the accepting edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- diff  output  WIDTH  registered result, a - b - bin mod 2^WIDTH
- bout  output  1  final borrow-out (unsigned a < b + bin)
- ovf  output  1  signed two's-complement overflow flag

Behaviour:
- Reset (asynchronous on rst_n=0): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal shift registers, bit counter and borrow flop cleared.
- Release of reset has no other effect; the first start is accepted on the next edge.
- States:
  - IDLE: on an edge with start=1, load a, b into shift registers, load borrow flop with bin, counter=0, go to SHIFT, busy=1.
  - SHIFT: each edge processes one bit, LSB first.
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the result register from the MSB side; operand registers shift right; counter increments.
    - On the edge processing bit WIDTH-1, go to DONE.
    - On that same edge: diff <= assembled result; bout <= final borrow; ovf <= (a_msb != b_msb) && (diff_msb != a_msb), using MSBs captured at load; done=1; busy=0.
  - DONE: lasts exactly one cycle.
    - start=1 on this edge: accepted exactly as in IDLE, go to SHIFT (back-to-back operation).
    - Otherwise go to IDLE.
    - done returns to 0 either way.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored; captured operands are unaffected.
- a, b and bin are don't-care except on the accepting edge.
- diff, bout and ovf change only on the completion edge or reset. They hold their value through IDLE and through the next operation until its completion.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no done pulse is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (WIDTH=8):
- Basic subtraction: a=0x35, b=0x12, bin=0, start pulsed at edge k -> busy=1 from k to k+8; done=1 for exactly one cycle after edge k+8; diff=0x23, bout=0, ovf=0.
- Unsigned underflow: a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1, ovf=0.
- Signed overflow and borrow-in:
  - a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
  - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- Start during busy: start 0x35-0x12, then pulse start with a=0xFF, b=0x00 at edge k+3 -> that second start is ignored; result is 0x23 at the normal time.
- Back-to-back: hold start=1 continuously with a=0x10, b=0x01 -> done pulses every 9 cycles; diff=0x0F each time; busy drops for only the DONE cycle.
- Reset mid-operation: assert rst_n=0 at edge k+4 for 2 cycles -> busy, done, diff, bout, ovf are all 0 asynchronously; no done pulse follows; a new start then completes normally (0x35-0x12=0x23).

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues requests and the slave side returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flop,
// producing a - b - bin after WIDTH shift cycles with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             a0, b0, d_bit, br_next, last_bit;

  assign a0       = a_sh_q[0];
  assign b0       = b_sh_q[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = SHIFT;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, handshake
// corner sequences and randomized operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_diff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: unsigned and signed results of a - b - bin.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    longint ua, ub, sa, sb, ur, sr;
    logic [63:0] bits;
    logic bo, ov;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb   = b[W-1] ? ub - (longint'(1) << W) : ub;
    ur   = ua - ub - longint'(bin);
    sr   = sa - sb - longint'(bin);
    bits = ur;
    bo   = (ur < 0);
    ov   = (sr < -(longint'(1) << (W - 1))) || (sr > (longint'(1) << (W - 1)) - 1);
    return {ov, bo, bits[W-1:0]};
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
    checkOutput("diff_held_into_op", 64'(bus.diff), 64'(prev_diff));
  endtask

  // Counts falling edges until done is seen; busy must stay high until then.
  task automatic awaitDone(input string name, output int n);
    logic busy_ok;
    busy_ok = 1'b1;
    n = 0;
    for (int i = 1; i <= 4 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    checkOutput({name, "_busy_during_op"}, 64'(busy_ok), 64'd1);
    checkOutput({name, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic [W-1:0] ediff, input logic ebout,
                       input logic eovf);
    int n;
    applyStimulus(a, b, bin);
    awaitDone(name, n);
    checkOutput({name, "_latency"}, 64'(n), 64'(W));
    checkOutput({name, "_diff"}, 64'(bus.diff), 64'(ediff));
    checkOutput({name, "_bout"}, 64'(bus.bout), 64'(ebout));
    checkOutput({name, "_ovf"}, 64'(bus.ovf), 64'(eovf));
    @(negedge clk);
    checkOutput({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    prev_diff = ediff;
  endtask

  initial begin
    int n;
    logic saw_done;
    logic [W+1:0] exp;
    logic [W-1:0] ra, rb;
    logic rbin;

    vecs[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, diff: 8'h23, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h12, b: 8'h35, bin: 1'b0, diff: 8'hDD, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    prev_diff = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_diff", 64'(bus.diff), 64'd0);
    checkOutput("reset_bout_ovf", 64'({bus.bout, bus.ovf}), 64'd0);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++)
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
            vecs[i].diff, vecs[i].bout, vecs[i].ovf);

    $display("[TB] start while busy is ignored");
    applyStimulus(8'h35, 8'h12, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    bus.bin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    awaitDone("ignore", n);
    checkOutput("ignore_latency", 64'(n), 64'(W - 3));
    checkOutput("ignore_diff", 64'(bus.diff), 64'h23);
    checkOutput("ignore_bout_ovf", 64'({bus.bout, bus.ovf}), 64'd0);
    @(negedge clk);
    checkOutput("ignore_no_requeue", 64'({bus.busy, bus.done}), 64'd0);
    prev_diff = 8'h23;

    $display("[TB] back-to-back operation");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    for (int r = 0; r < 3; r++) begin
      awaitDone($sformatf("b2b%0d", r), n);
      checkOutput($sformatf("b2b%0d_period", r), 64'(n), 64'(W + 1));
      checkOutput($sformatf("b2b%0d_diff", r), 64'(bus.diff), 64'h0F);
    end
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_stop", 64'({bus.busy, bus.done}), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("idle_hold_diff", 64'(bus.diff), 64'h0F);
    prev_diff = 8'h0F;

    $display("[TB] reset during operation");
    runOp("pre_reset", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    applyStimulus(8'h35, 8'h12, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_diff", 64'(bus.diff), 64'd0);
    checkOutput("midreset_flags", 64'({bus.busy, bus.done, bus.bout, bus.ovf}), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("midreset_held", 64'({bus.busy, bus.done, bus.diff}), 64'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checkOutput("midreset_no_done", 64'(saw_done), 64'd0);
    prev_diff = '0;
    runOp("post_reset", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      exp  = model(ra, rb, rbin);
      runOp($sformatf("rand%0d", i), ra, rb, rbin, exp[W-1:0], exp[W], exp[W+1]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
